// File: rtl/aes_128_round_ctrl_if.sv
// ----------------------------------------------------------------------------
// aes_128_round_ctrl_if
// Bundles the block handshake and datapath control signals of the AES-128
// round controller.
//   master : controller side (drives in_ready, out_valid and datapath controls)
//   slave  : producer/consumer/datapath side (drives abort, in_valid, out_ready)
// Signals:
//   abort      synchronous abort of the current block
//   in_valid   new block available      / in_ready   controller idle
//   out_valid  result in state register / out_ready  downstream consumes
//   sel_in     state mux: 1 = input block, 0 = round result
//   key_addr   round-key RAM address
//   sbox_en    S-box BRAM read enable
//   mix_kill   clears MixColumns register
//   mix_bypass MixColumns pass-through (final round)
//   ark_en     state register load
//   round      current round number
//   busy       block in flight
// ----------------------------------------------------------------------------
interface aes_128_round_ctrl_if #(
    parameter int unsigned KEY_AW = 4
);
    logic              abort;
    logic              in_valid;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic              sel_in;
    logic [KEY_AW-1:0] key_addr;
    logic              sbox_en;
    logic              mix_kill;
    logic              mix_bypass;
    logic              ark_en;
    logic [KEY_AW-1:0] round;
    logic              busy;

    modport master (
        input  abort, in_valid, out_ready,
        output in_ready, out_valid, sel_in, key_addr, sbox_en, mix_kill,
               mix_bypass, ark_en, round, busy
    );

    modport slave (
        output abort, in_valid, out_ready,
        input  in_ready, out_valid, sel_in, key_addr, sbox_en, mix_kill,
               mix_bypass, ark_en, round, busy
    );
endinterface

// File: rtl/aes_128_round_ctrl.sv
// ----------------------------------------------------------------------------
// aes_128_round_ctrl
// Sequencer for the iterative AES-128 round datapath (S-box BRAM stage,
// MixColumns register stage, AddRoundKey/state register stage), 3 cycles per
// round. Accepts a block via in_valid/in_ready, runs the initial AddRoundKey
// plus NR rounds, then holds out_valid until out_ready. No data passes here.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    aes_128_round_ctrl_if.master (handshakes + datapath controls)
// All outputs are registers decoded from the next state, so they are a pure
// function of the current state/counters with no input-to-output path.
// ----------------------------------------------------------------------------
module aes_128_round_ctrl #(
    parameter int unsigned NR     = 10,
    parameter int unsigned KEY_AW = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    aes_128_round_ctrl_if.master        bus
);

    typedef enum logic [1:0] {
        StIdle,
        StInit,
        StRound,
        StDone
    } state_e;

    localparam logic [KEY_AW-1:0] LastRnd = KEY_AW'(NR);

    state_e            state_q, state_d;
    logic [KEY_AW-1:0] rnd_q, rnd_d;
    logic [1:0]        ph_q, ph_d;

    logic              in_ready_d;
    logic              out_valid_d;
    logic              sel_in_d;
    logic [KEY_AW-1:0] key_addr_d;
    logic              sbox_en_d;
    logic              mix_kill_d;
    logic              mix_bypass_d;
    logic              ark_en_d;
    logic [KEY_AW-1:0] round_d;
    logic              busy_d;

    // Next state and counters.
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        ph_d    = ph_q;
        if (bus.abort) begin
            state_d = StIdle;
            rnd_d   = '0;
            ph_d    = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        state_d = StInit;
                        rnd_d   = '0;
                        ph_d    = '0;
                    end
                end
                StInit: begin
                    state_d = StRound;
                    rnd_d   = KEY_AW'(1);
                    ph_d    = '0;
                end
                StRound: begin
                    if (ph_q == 2'd2) begin
                        ph_d = '0;
                        if (rnd_q == LastRnd) begin
                            state_d = StDone;
                        end else begin
                            rnd_d = rnd_q + KEY_AW'(1);
                        end
                    end else begin
                        ph_d = ph_q + 2'd1;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        state_d = StIdle;
                        rnd_d   = '0;
                        ph_d    = '0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    rnd_d   = '0;
                    ph_d    = '0;
                end
            endcase
        end
    end

    // Output decode of the upcoming state; registered below.
    always_comb begin
        in_ready_d   = 1'b0;
        out_valid_d  = 1'b0;
        sel_in_d     = 1'b0;
        key_addr_d   = '0;
        sbox_en_d    = 1'b0;
        mix_kill_d   = 1'b0;
        mix_bypass_d = 1'b0;
        ark_en_d     = 1'b0;
        round_d      = '0;
        busy_d       = 1'b0;
        case (state_d)
            StIdle: begin
                in_ready_d = 1'b1;
                mix_kill_d = 1'b1;
            end
            StInit: begin
                sel_in_d   = 1'b1;
                ark_en_d   = 1'b1;
                mix_kill_d = 1'b1;
                busy_d     = 1'b1;
            end
            StRound: begin
                busy_d     = 1'b1;
                key_addr_d = rnd_d;
                round_d    = rnd_d;
                case (ph_d)
                    2'd0:    sbox_en_d    = 1'b1;
                    // Final round skips MixColumns.
                    2'd1:    mix_bypass_d = (rnd_d == LastRnd);
                    2'd2:    ark_en_d     = 1'b1;
                    default: ;
                endcase
            end
            StDone: begin
                out_valid_d = 1'b1;
                mix_kill_d  = 1'b1;
                round_d     = LastRnd;
            end
            default: begin
                in_ready_d = 1'b1;
                mix_kill_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            rnd_q          <= '0;
            ph_q           <= '0;
            bus.in_ready   <= 1'b1;
            bus.out_valid  <= 1'b0;
            bus.sel_in     <= 1'b0;
            bus.key_addr   <= '0;
            bus.sbox_en    <= 1'b0;
            bus.mix_kill   <= 1'b1;
            bus.mix_bypass <= 1'b0;
            bus.ark_en     <= 1'b0;
            bus.round      <= '0;
            bus.busy       <= 1'b0;
        end else begin
            state_q        <= state_d;
            rnd_q          <= rnd_d;
            ph_q           <= ph_d;
            bus.in_ready   <= in_ready_d;
            bus.out_valid  <= out_valid_d;
            bus.sel_in     <= sel_in_d;
            bus.key_addr   <= key_addr_d;
            bus.sbox_en    <= sbox_en_d;
            bus.mix_kill   <= mix_kill_d;
            bus.mix_bypass <= mix_bypass_d;
            bus.ark_en     <= ark_en_d;
            bus.round      <= round_d;
            bus.busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_aes_128_round_ctrl.sv
// ----------------------------------------------------------------------------
// tb_aes_128_round_ctrl
// Directed bench for aes_128_round_ctrl. Stimulus pushes the expected cycle of
// each out_valid rising edge into a queue; a monitor pops and compares on
// every rising edge of out_valid and counts completed result handshakes.
// ----------------------------------------------------------------------------
module tb_aes_128_round_ctrl;

    localparam int unsigned NR     = 10;
    localparam int unsigned KEY_AW = 4;
    localparam int          LAT    = 3 * NR + 2;   // accept -> out_valid

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    aes_128_round_ctrl_if #(.KEY_AW(KEY_AW)) bus ();

    aes_128_round_ctrl #(
        .NR     (NR),
        .KEY_AW (KEY_AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    int hs_count = 0;
    bit ov_prev  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Raise in_valid during the current cycle; optionally expect a result.
    task automatic issue(output int t, input bit expect_done);
        bus.in_valid = 1'b1;
        t = cyc;
        if (expect_done) exp_q.push_back(t + LAT);
    endtask

    task automatic run_block(input string tag);
        int t;
        next_cycle();
        bus.out_ready = 1'b1;
        issue(t, 1'b1);
        for (int k = 0; k <= LAT + 1; k++) begin
            if (k > 0) begin
                next_cycle();
                bus.in_valid = 1'b0;
            end
            sample();
            check({tag, "_out_valid"}, int'(bus.out_valid), int'(k == LAT));
            check({tag, "_in_ready"}, int'(bus.in_ready), int'(k == 0 || k == LAT + 1));
        end
    endtask

    // Scoreboard monitor.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (bus.out_valid && !ov_prev) begin
                if (exp_q.size() == 0) begin
                    check("out_valid_unexpected", int'(bus.out_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_cycle", cyc, e);
                    check("done_round", int'(bus.round), NR);
                end
            end
            if (bus.out_valid && bus.out_ready && !bus.abort) hs_count++;
            ov_prev = bus.out_valid;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int hs_before;
        bus.abort     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // Reset values
        #1 rst_n = 1'b0;
        #2;
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_mix_kill", int'(bus.mix_kill), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_ark_en", int'(bus.ark_en), 0);
        check("rst_sbox_en", int'(bus.sbox_en), 0);
        check("rst_round", int'(bus.round), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Single block, full output trace
        next_cycle();
        bus.out_ready = 1'b1;
        issue(t, 1'b1);
        for (int k = 0; k <= 33; k++) begin
            bit in_rnd;
            if (k > 0) begin
                next_cycle();
                bus.in_valid = 1'b0;
            end
            sample();
            in_rnd = (k >= 2 && k <= 31);
            check("s1_in_ready", int'(bus.in_ready), int'(k == 0 || k == 33));
            check("s1_sbox_en", int'(bus.sbox_en), int'(in_rnd && (k - 2) % 3 == 0));
            check("s1_ark_en", int'(bus.ark_en),
                  int'(k == 1 || (k >= 4 && k <= 31 && (k - 1) % 3 == 0)));
            check("s1_mix_bypass", int'(bus.mix_bypass), int'(k == 30));
            check("s1_out_valid", int'(bus.out_valid), int'(k == 32));
            check("s1_sel_in", int'(bus.sel_in), int'(k == 1));
            check("s1_key_addr", int'(bus.key_addr), in_rnd ? (k - 2) / 3 + 1 : 0);
            check("s1_busy", int'(bus.busy), int'(k >= 1 && k <= 31));
            if (!(in_rnd && (k - 2) % 3 == 2))
                check("s1_mix_kill", int'(bus.mix_kill), int'(!in_rnd));
        end

        // Backpressure: hold DONE for 20 cycles
        next_cycle();
        bus.out_ready = 1'b0;
        issue(t, 1'b1);
        for (int k = 0; k <= 53; k++) begin
            if (k > 0) begin
                next_cycle();
                bus.in_valid = 1'b0;
                if (k == 52) bus.out_ready = 1'b1;
            end
            sample();
            if (k >= 32 && k <= 52) begin
                check("s2_out_valid", int'(bus.out_valid), 1);
                check("s2_round", int'(bus.round), 10);
                check("s2_in_ready", int'(bus.in_ready), 0);
            end
            if (k == 53) begin
                check("s2_release_out_valid", int'(bus.out_valid), 0);
                check("s2_release_in_ready", int'(bus.in_ready), 1);
            end
        end

        // Back-to-back with in_valid held high
        next_cycle();
        bus.out_ready = 1'b1;
        issue(t, 1'b1);
        exp_q.push_back(t + 33 + LAT);
        exp_q.push_back(t + 66 + LAT);
        for (int k = 0; k <= 99; k++) begin
            if (k > 0) begin
                next_cycle();
                if (k == 67) bus.in_valid = 1'b0;
            end
            sample();
            check("s3_in_ready", int'(bus.in_ready), int'(k % 33 == 0));
            check("s3_out_valid", int'(bus.out_valid), int'(k % 33 == 32));
        end

        // Abort at rnd=5, ph=1
        next_cycle();
        issue(t, 1'b0);
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) begin
                next_cycle();
                bus.in_valid = 1'b0;
                bus.abort = (k == 15);
            end
            sample();
            if (k == 15) begin
                check("s4_abort_cycle_round", int'(bus.round), 5);
                check("s4_abort_cycle_mix_kill", int'(bus.mix_kill), 0);
                check("s4_abort_cycle_busy", int'(bus.busy), 1);
            end
            if (k >= 16) begin
                check("s4_idle_in_ready", int'(bus.in_ready), 1);
                check("s4_idle_mix_kill", int'(bus.mix_kill), 1);
                check("s4_idle_busy", int'(bus.busy), 0);
                check("s4_idle_out_valid", int'(bus.out_valid), 0);
            end
        end
        run_block("s4_after_abort");

        // Asynchronous reset mid-round
        next_cycle();
        issue(t, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            next_cycle();
            bus.in_valid = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        check("s5_rst_in_ready", int'(bus.in_ready), 1);
        check("s5_rst_mix_kill", int'(bus.mix_kill), 1);
        check("s5_rst_round", int'(bus.round), 0);
        check("s5_rst_busy", int'(bus.busy), 0);
        check("s5_rst_sbox_en", int'(bus.sbox_en), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        run_block("s5_after_reset");

        // Abort and out_ready together in DONE; abort also blocks an accept
        hs_before = hs_count;
        next_cycle();
        bus.out_ready = 1'b0;
        issue(t, 1'b1);
        for (int k = 0; k <= 36; k++) begin
            if (k > 0) begin
                next_cycle();
                bus.in_valid  = (k == 35);
                bus.abort     = (k == 34 || k == 35);
                bus.out_ready = (k == 34);
            end
            sample();
            if (k == 34) check("s6_done_out_valid", int'(bus.out_valid), 1);
            if (k == 35) begin
                check("s6_abort_out_valid", int'(bus.out_valid), 0);
                check("s6_abort_in_ready", int'(bus.in_ready), 1);
                check("s6_abort_mix_kill", int'(bus.mix_kill), 1);
            end
            if (k == 36) begin
                check("s6_no_accept_in_ready", int'(bus.in_ready), 1);
                check("s6_no_accept_busy", int'(bus.busy), 0);
            end
        end
        check("s6_handshakes", hs_count - hs_before, 0);

        repeat (3) next_cycle();
        check("pending_results", exp_q.size(), 0);
        check("total_handshakes", hs_count, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
